// File: rtl/result_trace_fifo_if.sv
// result_trace_fifo_if: retire-capture, trace-drain and loss-status signals of result_trace_fifo (trace_time only with TRACE_TIMESTAMP_EN)
interface result_trace_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 16
);
  logic capture_en;
  logic [DATA_W-1:0] datapath_result;
  logic [5:0] inst_31_26;
  logic [5:0] inst_5_0;
  logic trace_valid;
  logic trace_ready;
  logic [DATA_W+11:0] trace_data;
  logic [ADDR_W:0] count;
  logic full;
  logic empty;
  logic overflow;
  logic overflow_clr;
  logic [DROP_W-1:0] drop_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] trace_time;
  modport master (
    output capture_en, datapath_result, inst_31_26, inst_5_0, trace_ready, overflow_clr,
    input trace_valid, trace_data, count, full, empty, overflow, drop_count, trace_time
  );
  modport slave (
    input capture_en, datapath_result, inst_31_26, inst_5_0, trace_ready, overflow_clr,
    output trace_valid, trace_data, count, full, empty, overflow, drop_count, trace_time
  );
`else
  modport master (
    output capture_en, datapath_result, inst_31_26, inst_5_0, trace_ready, overflow_clr,
    input trace_valid, trace_data, count, full, empty, overflow, drop_count
  );
  modport slave (
    input capture_en, datapath_result, inst_31_26, inst_5_0, trace_ready, overflow_clr,
    output trace_valid, trace_data, count, full, empty, overflow, drop_count
  );
`endif
endinterface

// File: rtl/result_trace_fifo.sv
// result_trace_fifo: first-word-fall-through circular trace buffer of retired results with counted loss; TRACE_TIMESTAMP_EN adds per-entry cycle stamps on trace_time
module result_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter int DROP_W = 16
) (
  input logic clk,
  input logic reset,
  result_trace_fifo_if.slave bus
);
  localparam int ENT_W = DATA_W + 12;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [DROP_W-1:0] drop_count;
  logic overflow;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]};
  assign pop = ~empty & bus.trace_ready;
  assign push = bus.capture_en & (~full | pop);
  assign drop = bus.capture_en & full & ~pop;
  assign bus.trace_valid = ~empty;
  assign bus.trace_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
  assign bus.count = wr_ptr - rd_ptr;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.overflow = overflow;
  assign bus.drop_count = drop_count;
  // Entry storage is left unreset; the empty mask keeps stale contents off trace_data
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {bus.inst_31_26, bus.inst_5_0, bus.datapath_result};
  // Pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  // Loss accounting; a drop coincident with a clear restarts the tally at one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_count <= bus.overflow_clr ? DROP_W'(1) : drop_count + DROP_W'(~&drop_count);
    end else if (bus.overflow_clr) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] time_mem [DEPTH];
  assign bus.trace_time = empty ? '0 : time_mem[rd_ptr[ADDR_W-1:0]];
  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) cycle_cnt <= '0;
    else cycle_cnt <= cycle_cnt + 32'd1;
  // Stamp of the push cycle stored alongside each entry
  always_ff @(posedge clk)
    if (push) time_mem[wr_ptr[ADDR_W-1:0]] <= cycle_cnt;
`endif
endmodule

// File: tb/tb_result_trace_fifo.sv
// tb_result_trace_fifo: directed scoreboard bench for result_trace_fifo
module tb_result_trace_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int mcount = 0;
  int mdrop = 0;
  logic mov = 1'b0;
  int mtime = 0;
  logic [43:0] exp_q[$];
  logic [31:0] tq[$];
  always #5 clk = ~clk;
  result_trace_fifo_if #(.DATA_W(32), .ADDR_W(3), .DROP_W(16)) bus();
  result_trace_fifo #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .DROP_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic check_status();
    chk("count", 64'(bus.count), 64'(mcount));
    chk("full", 64'(bus.full), 64'(mcount == 8));
    chk("empty", 64'(bus.empty), 64'(mcount == 0));
    chk("overflow", 64'(bus.overflow), 64'(mov));
    chk("drop_count", 64'(bus.drop_count), 64'(mdrop));
  endtask
  task automatic model_reset();
    exp_q.delete();
    tq.delete();
    mcount = 0;
    mdrop = 0;
    mov = 1'b0;
    mtime = 0;
  endtask
  task automatic cycle(input logic cap, input logic [31:0] d, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic clr);
    logic pop_m;
    logic push_m;
    logic drop_m;
    bus.capture_en = cap;
    bus.datapath_result = d;
    bus.inst_31_26 = op;
    bus.inst_5_0 = fn;
    bus.trace_ready = rdy;
    bus.overflow_clr = clr;
    #1;
    chk("trace_valid", 64'(bus.trace_valid), 64'(mcount > 0));
    if (mcount == 0) chk("idle_data", 64'(bus.trace_data), 64'(0));
    pop_m = rdy && mcount > 0;
    if (pop_m) begin
      chk("head", 64'(bus.trace_data), 64'(exp_q[0]));
`ifdef TRACE_TIMESTAMP_EN
      chk("head_time", 64'(bus.trace_time), 64'(tq[0]));
`endif
      void'(exp_q.pop_front());
      void'(tq.pop_front());
    end
    push_m = cap && (mcount < 8 || pop_m);
    drop_m = cap && !push_m;
    if (push_m) begin
      exp_q.push_back({op, fn, d});
      tq.push_back(32'(mtime));
    end
    mcount = mcount + int'(push_m) - int'(pop_m);
    if (drop_m) begin
      mov = 1'b1;
      mdrop = clr ? 1 : (mdrop == 65535 ? 65535 : mdrop + 1);
    end else if (clr) begin
      mov = 1'b0;
      mdrop = 0;
    end
    @(posedge clk);
    mtime++;
    @(negedge clk);
    check_status();
  endtask
  initial begin
    bus.capture_en = 1'b0;
    bus.datapath_result = '0;
    bus.inst_31_26 = '0;
    bus.inst_5_0 = '0;
    bus.trace_ready = 1'b0;
    bus.overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_valid", 64'(bus.trace_valid), 64'(0));
    chk("rst_data", 64'(bus.trace_data), 64'(0));
    check_status();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h11, 6'h00, 6'h20, 0, 0);
    cycle(1, 32'h22, 6'h00, 6'h20, 0, 0);
    cycle(1, 32'h33, 6'h00, 6'h20, 0, 0);
    chk("three_count", 64'(bus.count), 64'(3));
    chk("first_head", 64'(bus.trace_data), {20'h0, 6'h00, 6'h20, 32'h11});
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    chk("drained_empty", 64'(bus.empty), 64'(1));
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 32'(i), 6'(i), 6'(~i), 0, 0);
      if (i == 8) chk("full_at_8", 64'(bus.full), 64'(1));
    end
    chk("ovf_drops", 64'(bus.drop_count), 64'(2));
    repeat (8) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("clr_ovf", 64'(bus.overflow), 64'(0));
    for (int i = 1; i <= 8; i++) cycle(1, 32'(i), 6'h23, 6'h00, 0, 0);
    cycle(1, 32'd9, 6'h23, 6'h00, 1, 0);
    chk("full_swap_count", 64'(bus.count), 64'(8));
    chk("full_swap_nodrop", 64'(bus.drop_count), 64'(0));
    repeat (8) cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 32'(100 + i), 6'(i), 6'(3 * i), 1, 0);
      chk("wrap_max1", 64'(bus.count <= 1), 64'(1));
    end
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 32'(200 + i), 6'h0f, 6'h2a, 0, 0);
    cycle(1, 32'hdead, 6'h0f, 6'h2a, 0, 0);
    cycle(1, 32'hbeef, 6'h0f, 6'h2a, 0, 1);
    chk("clr_drop_ovf", 64'(bus.overflow), 64'(1));
    chk("clr_drop_cnt", 64'(bus.drop_count), 64'(1));
    repeat (8) cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'(300 + i), 6'h01, 6'h02, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_count", 64'(bus.count), 64'(0));
    chk("async_valid", 64'(bus.trace_valid), 64'(0));
    chk("async_data", 64'(bus.trace_data), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    check_status();
    repeat (7) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h77, 6'h02, 6'h03, 0, 0);
`ifdef TRACE_TIMESTAMP_EN
    chk("stamp7", 64'(bus.trace_time), 64'(7));
`endif
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
